// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_REL_BYTE,
        ST_RUN,
        ST_FAIL
    } pll_seq_state_t;

    localparam int LOSS_CNT_W = 8;

    // Shared cycle counter must reach the largest terminal count; one spare bit of headroom.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, clears to 0 on synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer with ordered byte/pixel domain reset release.
// Optional loss-of-lock counter built only when PLL_LOSS_CNT_EN is defined.
//
// state        | meaning
// IDLE         | waiting for enable, PLL held in reset
// PLL_RST      | PLL RST asserted for RST_CYCLES
// WAIT_LOCK    | waiting for synced lock, bounded by LOCK_TIMEOUT
// STABLE       | lock must hold for LOCK_STABLE consecutive cycles
// REL_BYTE     | byte domain released, RELEASE_GAP running
// RUN          | both domains released, watching for loss of lock
// FAIL         | retries exhausted, waits for enable low
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int LOCK_STABLE  = 256,
    parameter int RELEASE_GAP  = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  pll_lock,
    output logic                  pll_rst,
    output logic                  byte_rst_n,
    output logic                  pix_rst_n,
    output logic                  lock_ok,
    output logic                  fail,
    output logic [LOSS_CNT_W-1:0] loss_cnt
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, RELEASE_GAP);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(RELEASE_GAP - 1);

    pll_seq_state_t state, state_nx;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  retry, retry_nx, retry_inc;
    logic           lock_s;

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    assign retry_inc = retry + RW'(1);

    always_comb begin
        state_nx = state;
        retry_nx = retry;
        if (!enable) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_PLL_RST;
                    retry_nx = '0;
                end
                ST_PLL_RST: begin
                    if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still wins.
                    if (lock_s) begin
                        state_nx = ST_STABLE;
                    end else if (cnt == TO_LAST) begin
                        retry_nx = retry_inc;
                        state_nx = (retry_inc == RW'(MAX_RETRY)) ? ST_FAIL : ST_PLL_RST;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s)                 state_nx = ST_WAIT_LOCK;
                    else if (cnt == STABLE_LAST) state_nx = ST_REL_BYTE;
                end
                ST_REL_BYTE: begin
                    if (!lock_s)              state_nx = ST_PLL_RST;
                    else if (cnt == GAP_LAST) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nx = ST_PLL_RST;
                        retry_nx = '0;
                    end
                end
                ST_FAIL:  state_nx = ST_FAIL;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs decode the next state so they are valid in the first cycle of each state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            retry      <= '0;
            pll_rst    <= 1'b1;
            byte_rst_n <= 1'b0;
            pix_rst_n  <= 1'b0;
            lock_ok    <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= (state_nx != state) ? '0 : cnt + CW'(1);
            retry      <= retry_nx;
            pll_rst    <= (state_nx == ST_IDLE) || (state_nx == ST_PLL_RST) || (state_nx == ST_FAIL);
            byte_rst_n <= (state_nx == ST_REL_BYTE) || (state_nx == ST_RUN);
            pix_rst_n  <= (state_nx == ST_RUN);
            lock_ok    <= (state_nx == ST_RUN);
            fail       <= (state_nx == ST_FAIL);
        end
    end

`ifdef PLL_LOSS_CNT_EN
    logic                  loss_inc;
    logic [LOSS_CNT_W-1:0] loss_q;

    assign loss_inc = enable && (state == ST_RUN) && !lock_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + LOSS_CNT_W'(1);
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

endmodule
